// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel path: the FIFO word layout,
// the alignment FSM states and the visible-area geometry.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int DATA_W    = 12;

  localparam logic [DATA_W-1:0] RGB_BLACK = 12'h000;

  // sof marks the word that must be shown at pixel (0,0) of a frame
  typedef struct packed {
    logic              sof;
    logic [DATA_W-1:0] data;
  } pix_word_t;

  typedef enum logic {
    ALIGN = 1'b0,
    RUN   = 1'b1
  } fifo_state_t;

endpackage

// File: rtl/vga_pixel_fifo_if.sv
// Stream side (producer -> FIFO) and pixel side (FIFO <-> timing stage) of the
// VGA pixel feeder. The master modport is the surrounding system.
interface vga_pixel_fifo_if #(
  parameter int DATA_W = vga_pkg::DATA_W
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_sof;
  logic              pix_req;
  logic              pix_sof;
  logic [DATA_W-1:0] pix_rgb;

  modport master (
    output s_valid, s_data, s_sof, pix_req, pix_sof,
    input  s_ready, pix_rgb
  );

  modport slave (
    input  s_valid, s_data, s_sof, pix_req, pix_sof,
    output s_ready, pix_rgb
  );

endinterface

// File: rtl/vga_fifo_core.sv
// Synchronous FIFO of tagged pixel words. The head word is read combinationally
// so the alignment FSM can inspect its sof tag in the same cycle.
module vga_fifo_core
  import vga_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  pix_word_t        wr_word,
  output pix_word_t        rd_word,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  pix_word_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == LVL_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = count_reg;
  assign rd_word = mem[rd_ptr_reg];

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wr_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/vga_pixel_fifo.sv
// Pixel FIFO feeding the VGA timing stage: locks the stream to frame start via
// the sof tag, releases one pixel per request, and re-locks after any upset.
module vga_pixel_fifo
  import vga_pkg::pix_word_t, vga_pkg::fifo_state_t, vga_pkg::ALIGN,
         vga_pkg::RUN, vga_pkg::RGB_BLACK;
#(
  parameter  int DEPTH  = 16,
  parameter  int DATA_W = 12,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  vga_pixel_fifo_if.slave   bus,
  input  logic              clr_err,
  output logic              locked,
  output logic              underflow,
  output logic              misalign,
  output logic [LVL_W-1:0]  level
);

  fifo_state_t       state_reg;
  fifo_state_t       state_next;
  logic [DATA_W-1:0] rgb_reg;
  logic [DATA_W-1:0] rgb_next;
  logic              underflow_reg;
  logic              misalign_reg;
  logic              pop;
  logic              set_underflow;
  logic              set_misalign;
  logic              full;
  logic              empty;
  pix_word_t         head;
  pix_word_t         wr_word;

  assign wr_word.sof  = bus.s_sof;
  assign wr_word.data = bus.s_data;
  assign bus.s_ready  = !full;

  vga_fifo_core #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .push    (bus.s_valid && !full),
    .pop     (pop),
    .wr_word (wr_word),
    .rd_word (head),
    .full    (full),
    .empty   (empty),
    .count   (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ALIGN;
      rgb_reg       <= RGB_BLACK;
      underflow_reg <= 1'b0;
      misalign_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      rgb_reg   <= rgb_next;
      // a new error in the same cycle as clr_err must not be lost
      if (set_underflow) begin
        underflow_reg <= 1'b1;
      end else if (clr_err) begin
        underflow_reg <= 1'b0;
      end
      if (set_misalign) begin
        misalign_reg <= 1'b1;
      end else if (clr_err) begin
        misalign_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    rgb_next      = RGB_BLACK;
    pop           = 1'b0;
    set_underflow = 1'b0;
    set_misalign  = 1'b0;
    case (state_reg)
      ALIGN: begin
        // untagged words ahead of a frame start are stale and dropped
        if (!empty) begin
          if (!head.sof) begin
            pop = 1'b1;
          end else if (bus.pix_req && bus.pix_sof) begin
            pop        = 1'b1;
            rgb_next   = head.data;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (bus.pix_req) begin
          if (empty) begin
            set_underflow = 1'b1;
            state_next    = ALIGN;
          end else if (head.sof != bus.pix_sof) begin
            set_misalign = 1'b1;
            state_next   = ALIGN;
          end else begin
            pop      = 1'b1;
            rgb_next = head.data;
          end
        end
      end
      default: state_next = ALIGN;
    endcase
  end

  assign bus.pix_rgb = rgb_reg;
  assign locked      = (state_reg == RUN);
  assign underflow   = underflow_reg;
  assign misalign    = misalign_reg;

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Scoreboard bench for vga_pixel_fifo: directed frame scenarios, then random
// traffic, all predicted by a queue-based behavioural model.
module tb_vga_pixel_fifo;

  localparam int DEPTH = 16;
  localparam int LVL_W = 5;

  typedef struct packed {
    logic [11:0]      rgb;
    logic             locked;
    logic             uf;
    logic             ma;
    logic             rdy;
    logic [LVL_W-1:0] level;
  } obs_t;

  logic             clk;
  logic             rst;
  logic             clr_err;
  logic             locked;
  logic             underflow;
  logic             misalign;
  logic [LVL_W-1:0] level;

  vga_pixel_fifo_if #(.DATA_W(12)) bus_if ();

  vga_pixel_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (12)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .clr_err   (clr_err),
    .locked    (locked),
    .underflow (underflow),
    .misalign  (misalign),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc_no = 0;
  obs_t exp_q[$];

  // behavioural model: words waiting in the FIFO, lock state, sticky flags
  logic [12:0] mq[$];
  bit          m_locked;
  bit          m_uf;
  bit          m_ma;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_locked = 0;
    m_uf     = 0;
    m_ma     = 0;
  endtask

  task automatic drive_idle();
    bus_if.s_valid = 1'b0;
    bus_if.s_data  = '0;
    bus_if.s_sof   = 1'b0;
    bus_if.pix_req = 1'b0;
    bus_if.pix_sof = 1'b0;
    clr_err        = 1'b0;
  endtask

  // Drive one clock of stimulus (entered on a falling edge), predict the
  // state after the rising edge, and return on the next falling edge.
  task automatic cyc(input bit v, input logic [11:0] d, input bit s,
                     input bit req, input bit ps, input bit clr);
    bit          do_push, do_pop, nl, uf_set, ma_set;
    logic [11:0] rgb;
    obs_t        e;
    bus_if.s_valid = v;
    bus_if.s_data  = d;
    bus_if.s_sof   = s;
    bus_if.pix_req = req;
    bus_if.pix_sof = ps;
    clr_err        = clr;
    do_push = v && (mq.size() < DEPTH);
    do_pop  = 0;
    rgb     = 12'h000;
    nl      = m_locked;
    uf_set  = 0;
    ma_set  = 0;
    if (!m_locked) begin
      if (mq.size() != 0) begin
        if (!mq[0][12]) begin
          do_pop = 1;
        end else if (req && ps) begin
          do_pop = 1;
          rgb    = mq[0][11:0];
          nl     = 1;
        end
      end
    end else if (req) begin
      if (mq.size() == 0) begin
        uf_set = 1;
        nl     = 0;
      end else if (mq[0][12] != ps) begin
        ma_set = 1;
        nl     = 0;
      end else begin
        do_pop = 1;
        rgb    = mq[0][11:0];
      end
    end
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back({s, d});
    m_locked = nl;
    m_uf = uf_set ? 1'b1 : (clr ? 1'b0 : m_uf);
    m_ma = ma_set ? 1'b1 : (clr ? 1'b0 : m_ma);
    e.rgb    = rgb;
    e.locked = m_locked;
    e.uf     = m_uf;
    e.ma     = m_ma;
    e.rdy    = (mq.size() < DEPTH);
    e.level  = LVL_W'(mq.size());
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Reset asserted between clock edges; outputs must clear without an edge.
  task automatic async_reset();
    obs_t e;
    drive_idle();
    #2 rst = 1'b1;
    #1;
    chk("arst_level", 16'(level), 16'd0);
    chk("arst_locked", 16'(locked), 16'd0);
    chk("arst_rgb", 16'(bus_if.pix_rgb), 16'h000);
    chk("arst_underflow", 16'(underflow), 16'd0);
    chk("arst_misalign", 16'(misalign), 16'd0);
    model_reset();
    e = '0;
    e.rdy = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // monitor: compare every post-edge observation against the scoreboard
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      cyc_no++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a.rgb    = bus_if.pix_rgb;
        a.locked = locked;
        a.uf     = underflow;
        a.ma     = misalign;
        a.rdy    = bus_if.s_ready;
        a.level  = level;
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL scoreboard cycle %0d: got rgb=%h locked=%b uf=%b ma=%b rdy=%b level=%0d, expected rgb=%h locked=%b uf=%b ma=%b rdy=%b level=%0d",
                   cyc_no, a.rgb, a.locked, a.uf, a.ma, a.rdy, a.level,
                   e.rgb, e.locked, e.uf, e.ma, e.rdy, e.level);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal;
  end

  logic [11:0] t1_pix [4];

  initial begin
    t1_pix[0] = 12'hF00;
    t1_pix[1] = 12'h0F0;
    t1_pix[2] = 12'h00F;
    t1_pix[3] = 12'hFFF;
    rst = 1'b1;
    drive_idle();
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_level", 16'(level), 16'd0);
    chk("reset_ready", 16'(bus_if.s_ready), 16'd1);
    chk("reset_locked", 16'(locked), 16'd0);
    chk("reset_rgb", 16'(bus_if.pix_rgb), 16'h000);
    rst = 1'b0;

    // 1: tagged frame start then three more pixels
    for (int i = 0; i < 4; i++) cyc(1, t1_pix[i], i == 0, 0, 0, 0);
    chk("t1_level_loaded", 16'(level), 16'd4);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 12'h0, 0, 1, i == 0, 0);
      chk("t1_rgb", 16'(bus_if.pix_rgb), 16'(t1_pix[i]));
      chk("t1_locked", 16'(locked), 16'd1);
    end
    chk("t1_level_drained", 16'(level), 16'd0);

    // 3: underflow while locked
    cyc(1, 12'h111, 0, 0, 0, 0);
    cyc(1, 12'h222, 0, 0, 0, 0);
    cyc(0, 12'h0, 0, 1, 0, 0);
    chk("t3_rgb0", 16'(bus_if.pix_rgb), 16'h111);
    cyc(0, 12'h0, 0, 1, 0, 0);
    chk("t3_rgb1", 16'(bus_if.pix_rgb), 16'h222);
    cyc(0, 12'h0, 0, 1, 0, 0);
    chk("t3_rgb_black", 16'(bus_if.pix_rgb), 16'h000);
    chk("t3_underflow", 16'(underflow), 16'd1);
    chk("t3_unlocked", 16'(locked), 16'd0);
    cyc(0, 12'h0, 0, 0, 0, 1);
    chk("t3_cleared", 16'(underflow), 16'd0);
    chk("t3_still_align", 16'(locked), 16'd0);

    // 2: stale untagged words are discarded in ALIGN
    cyc(1, 12'h3A1, 0, 0, 0, 0);
    cyc(1, 12'h3A2, 0, 0, 0, 0);
    cyc(1, 12'h3A3, 0, 0, 0, 0);
    cyc(1, 12'hABC, 1, 0, 0, 0);
    cyc(0, 12'h0, 0, 0, 0, 0);
    chk("t2_level", 16'(level), 16'd1);
    cyc(0, 12'h0, 0, 1, 1, 0);
    chk("t2_rgb", 16'(bus_if.pix_rgb), 16'hABC);
    chk("t2_locked", 16'(locked), 16'd1);

    // 4: tag/request disagreement while locked
    cyc(1, 12'h123, 1, 0, 0, 0);
    cyc(0, 12'h0, 0, 1, 0, 0);
    chk("t4_misalign", 16'(misalign), 16'd1);
    chk("t4_unlocked", 16'(locked), 16'd0);
    chk("t4_no_pop", 16'(level), 16'd1);
    chk("t4_rgb_black", 16'(bus_if.pix_rgb), 16'h000);
    cyc(0, 12'h0, 0, 1, 1, 0);
    chk("t4_relock", 16'(locked), 16'd1);
    chk("t4_rgb", 16'(bus_if.pix_rgb), 16'h123);
    cyc(0, 12'h0, 0, 0, 0, 1);
    chk("t4_cleared", 16'(misalign), 16'd0);

    // 5: full boundary
    for (int i = 0; i < DEPTH; i++) cyc(1, 12'(12'h500 + i), i == 0, 0, 0, 0);
    chk("t5_full_level", 16'(level), 16'd16);
    chk("t5_ready_low", 16'(bus_if.s_ready), 16'd0);
    cyc(1, 12'h777, 0, 0, 0, 0);
    chk("t5_no_store", 16'(level), 16'd16);
    cyc(1, 12'h888, 0, 1, 1, 0);
    chk("t5_pop_while_full", 16'(level), 16'd15);
    chk("t5_rgb", 16'(bus_if.pix_rgb), 16'h500);
    cyc(1, 12'h999, 0, 0, 0, 0);
    chk("t5_refill", 16'(level), 16'd16);
    for (int i = 0; i < 7; i++) cyc(0, 12'h0, 0, 1, 0, 0);
    chk("t6_pre_level", 16'(level), 16'd9);
    chk("t6_pre_locked", 16'(locked), 16'd1);

    // 6: async reset mid-frame
    async_reset();
    cyc(0, 12'h0, 0, 0, 0, 0);
    chk("t6_ready", 16'(bus_if.s_ready), 16'd1);
    chk("t6_level", 16'(level), 16'd0);

    // random traffic, with an occasional mid-stream reset
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) begin
        async_reset();
      end else begin
        cyc($urandom_range(0, 3) != 0, 12'($urandom), $urandom_range(0, 15) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 31) == 0);
      end
    end

    drive_idle();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
